wb_stage_pipelined: RTL and testbench

- Parametrised MEM/WB pipeline register fused with the write-back stage of the MIPS datapath.
- Captures memory-stage results every cycle and supports stall (hold) and flush (bubble).
- Performs load byte/halfword extraction with sign/zero extension and selects the write-back source (ALU, memory, link PC+8).
- Suppresses writes to register 0, drives forwarding taps toward EX, and counts retired instructions.

---
 rtl/wb_pkg.sv | 17 +
 rtl/load_extend.sv | 44 ++++
 rtl/wb_stage_pipelined.sv | 139 +++++++++++++
 tb/tb_wb_stage_pipelined.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared encodings for the MEM/WB write-back stage.
//   WbSel    : write-back source select (ALU / MEM / LINK; 3 is reserved and behaves as ALU)
//   LoadSize : load width (BYTE / HALF / WORD; 3 is reserved and behaves as WORD)
//   LINK_OFFSET : added to PC+4 to form the link address (PC+8)
package wb_pkg;

    localparam logic [1:0] WB_ALU  = 2'd0;
    localparam logic [1:0] WB_MEM  = 2'd1;
    localparam logic [1:0] WB_LINK = 2'd2;

    localparam logic [1:0] LD_BYTE = 2'd0;
    localparam logic [1:0] LD_HALF = 2'd1;
    localparam logic [1:0] LD_WORD = 2'd2;

    localparam int unsigned LINK_OFFSET = 4;

endpackage

// File: rtl/load_extend.sv
// Big-endian load lane extraction with sign/zero extension. Purely combinational.
//   r_data_i        : raw word from data memory
//   byte_off_i      : address bits [1:0] of the load
//   load_size_i     : LD_BYTE / LD_HALF / LD_WORD
//   load_unsigned_i : 1 = zero-extend, 0 = sign-extend
//   data_o          : extended load value
// The addressed word occupies bits [31:0]; DATA_W must be at least 32.
module load_extend
    import wb_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic [DATA_W-1:0] r_data_i,
    input  logic [1:0]        byte_off_i,
    input  logic [1:0]        load_size_i,
    input  logic              load_unsigned_i,
    output logic [DATA_W-1:0] data_o
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        // Offset 0 is the most significant byte of the word.
        unique case (byte_off_i)
            2'd0:    byte_lane = r_data_i[31:24];
            2'd1:    byte_lane = r_data_i[23:16];
            2'd2:    byte_lane = r_data_i[15:8];
            default: byte_lane = r_data_i[7:0];
        endcase
        // Only bit 1 of the offset picks the halfword; bit 0 is ignored.
        half_lane = byte_off_i[1] ? r_data_i[15:0] : r_data_i[31:16];
    end

    always_comb begin
        data_o = r_data_i;
        case (load_size_i)
            LD_BYTE: data_o = {{(DATA_W-8){byte_lane[7] & ~load_unsigned_i}}, byte_lane};
            LD_HALF: data_o = {{(DATA_W-16){half_lane[15] & ~load_unsigned_i}}, half_lane};
            default: data_o = r_data_i;
        endcase
    end

endmodule

// File: rtl/wb_stage_pipelined.sv
// MEM/WB pipeline register fused with the write-back stage.
//   Clk, Rst_n        : rising-edge clock, asynchronous active-low reset
//   Stall, Flush      : hold the WB register / load a bubble (Flush wins)
//   *_In              : MEM-stage instruction fields captured each edge
//   RegWrite_Out, rDest_Out, regWriteData : register-file write port
//   Fwd_Valid, Fwd_Addr, Fwd_Data         : forwarding tap toward EX (mirrors write port)
//   RetireCount       : valid instructions that have left the WB register
// All outputs depend only on registered state; there is no input-to-output path.
module wb_stage_pipelined
    import wb_pkg::*;
#(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned CNT_W      = 32
) (
    input  logic                  Clk,
    input  logic                  Rst_n,
    input  logic                  Stall,
    input  logic                  Flush,
    input  logic                  Valid_In,
    input  logic                  RegWrite_In,
    input  logic [1:0]            WbSel_In,
    input  logic [1:0]            LoadSize_In,
    input  logic                  LoadUnsigned_In,
    input  logic [1:0]            ByteOff_In,
    input  logic [DATA_W-1:0]     R_Data_In,
    input  logic [DATA_W-1:0]     ALUResult_In,
    input  logic [DATA_W-1:0]     PCPlus4_In,
    input  logic [REG_ADDR_W-1:0] rDest_In,
    output logic                  RegWrite_Out,
    output logic [REG_ADDR_W-1:0] rDest_Out,
    output logic [DATA_W-1:0]     regWriteData,
    output logic                  Fwd_Valid,
    output logic [REG_ADDR_W-1:0] Fwd_Addr,
    output logic [DATA_W-1:0]     Fwd_Data,
    output logic [CNT_W-1:0]      RetireCount
);

    logic                  valid_q;
    logic                  reg_write_q;
    logic [1:0]            wb_sel_q;
    logic [1:0]            load_size_q;
    logic                  load_unsigned_q;
    logic [1:0]            byte_off_q;
    logic [DATA_W-1:0]     r_data_q;
    logic [DATA_W-1:0]     alu_result_q;
    logic [DATA_W-1:0]     pc_plus4_q;
    logic [REG_ADDR_W-1:0] rdest_q;
    logic [CNT_W-1:0]      retire_cnt_q;
    logic [CNT_W-1:0]      retire_cnt_d;

    logic [DATA_W-1:0]     load_data;
    logic [DATA_W-1:0]     wb_data;
    logic                  wr_en;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            valid_q         <= 1'b0;
            reg_write_q     <= 1'b0;
            wb_sel_q        <= '0;
            load_size_q     <= '0;
            load_unsigned_q <= 1'b0;
            byte_off_q      <= '0;
            r_data_q        <= '0;
            alu_result_q    <= '0;
            pc_plus4_q      <= '0;
            rdest_q         <= '0;
        end else if (Flush) begin
            // Clear every field so a bubble drives all-zero outputs.
            valid_q         <= 1'b0;
            reg_write_q     <= 1'b0;
            wb_sel_q        <= '0;
            load_size_q     <= '0;
            load_unsigned_q <= 1'b0;
            byte_off_q      <= '0;
            r_data_q        <= '0;
            alu_result_q    <= '0;
            pc_plus4_q      <= '0;
            rdest_q         <= '0;
        end else if (!Stall) begin
            valid_q         <= Valid_In;
            reg_write_q     <= RegWrite_In;
            wb_sel_q        <= WbSel_In;
            load_size_q     <= LoadSize_In;
            load_unsigned_q <= LoadUnsigned_In;
            byte_off_q      <= ByteOff_In;
            r_data_q        <= R_Data_In;
            alu_result_q    <= ALUResult_In;
            pc_plus4_q      <= PCPlus4_In;
            rdest_q         <= rDest_In;
        end
    end

    // An instruction is counted when it leaves the register: advanced or flushed.
    always_comb begin
        retire_cnt_d = retire_cnt_q;
        if (valid_q && (!Stall || Flush)) begin
            retire_cnt_d = retire_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            retire_cnt_q <= '0;
        end else begin
            retire_cnt_q <= retire_cnt_d;
        end
    end

    load_extend #(
        .DATA_W (DATA_W)
    ) u_load_extend (
        .r_data_i        (r_data_q),
        .byte_off_i      (byte_off_q),
        .load_size_i     (load_size_q),
        .load_unsigned_i (load_unsigned_q),
        .data_o          (load_data)
    );

    always_comb begin
        wb_data = alu_result_q;
        case (wb_sel_q)
            WB_MEM:  wb_data = load_data;
            WB_LINK: wb_data = pc_plus4_q + DATA_W'(LINK_OFFSET);
            default: wb_data = alu_result_q;
        endcase
    end

    assign wr_en        = valid_q & reg_write_q & (rdest_q != '0);

    assign RegWrite_Out = wr_en;
    assign rDest_Out    = rdest_q;
    assign regWriteData = wb_data;
    assign Fwd_Valid    = wr_en;
    assign Fwd_Addr     = rdest_q;
    assign Fwd_Data     = wb_data;
    assign RetireCount  = retire_cnt_q;

endmodule

// File: tb/tb_wb_stage_pipelined.sv
// Self-checking bench for wb_stage_pipelined: directed vector table, hand sequences for
// stall/flush/reset/wrap, then randomized traffic against a behavioural model.
module tb_wb_stage_pipelined;

    typedef struct packed {
        logic        v;
        logic        we;
        logic [1:0]  sel;
        logic [1:0]  lsz;
        logic        uns;
        logic [1:0]  off;
        logic [31:0] rd;
        logic [31:0] alu;
        logic [31:0] pc4;
        logic [4:0]  dst;
    } instr_t;

    typedef struct {
        string       name;
        instr_t      in;
        logic [31:0] exp_d;
        logic        exp_we;
    } vec_t;

    logic        Clk, Rst_n, Stall, Flush;
    logic        Valid_In, RegWrite_In, LoadUnsigned_In;
    logic [1:0]  WbSel_In, LoadSize_In, ByteOff_In;
    logic [31:0] R_Data_In, ALUResult_In, PCPlus4_In;
    logic [4:0]  rDest_In;

    logic        we_o, fv_o, we4_o, fv4_o;
    logic [4:0]  dst_o, fa_o, dst4_o, fa4_o;
    logic [31:0] wd_o, fd_o, wd4_o, fd4_o;
    logic [31:0] cnt_o;
    logic [3:0]  cnt4_o;

    int unsigned total = 0;
    int unsigned bad   = 0;

    instr_t      cur;
    instr_t      held;
    int unsigned mcnt;
    vec_t        tbl[$];

    wb_stage_pipelined #(.DATA_W(32), .REG_ADDR_W(5), .CNT_W(32)) dut (
        .Clk(Clk), .Rst_n(Rst_n), .Stall(Stall), .Flush(Flush), .Valid_In(Valid_In),
        .RegWrite_In(RegWrite_In), .WbSel_In(WbSel_In), .LoadSize_In(LoadSize_In),
        .LoadUnsigned_In(LoadUnsigned_In), .ByteOff_In(ByteOff_In), .R_Data_In(R_Data_In),
        .ALUResult_In(ALUResult_In), .PCPlus4_In(PCPlus4_In), .rDest_In(rDest_In),
        .RegWrite_Out(we_o), .rDest_Out(dst_o), .regWriteData(wd_o), .Fwd_Valid(fv_o),
        .Fwd_Addr(fa_o), .Fwd_Data(fd_o), .RetireCount(cnt_o)
    );

    wb_stage_pipelined #(.DATA_W(32), .REG_ADDR_W(5), .CNT_W(4)) dut4 (
        .Clk(Clk), .Rst_n(Rst_n), .Stall(Stall), .Flush(Flush), .Valid_In(Valid_In),
        .RegWrite_In(RegWrite_In), .WbSel_In(WbSel_In), .LoadSize_In(LoadSize_In),
        .LoadUnsigned_In(LoadUnsigned_In), .ByteOff_In(ByteOff_In), .R_Data_In(R_Data_In),
        .ALUResult_In(ALUResult_In), .PCPlus4_In(PCPlus4_In), .rDest_In(rDest_In),
        .RegWrite_Out(we4_o), .rDest_Out(dst4_o), .regWriteData(wd4_o), .Fwd_Valid(fv4_o),
        .Fwd_Addr(fa4_o), .Fwd_Data(fd4_o), .RetireCount(cnt4_o)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    function automatic instr_t mk(input logic v, input logic we, input logic [1:0] sel,
                                  input logic [1:0] lsz, input logic uns, input logic [1:0] off,
                                  input logic [31:0] rd, input logic [31:0] alu,
                                  input logic [31:0] pc4, input logic [4:0] dst);
        instr_t r;
        r.v = v; r.we = we; r.sel = sel; r.lsz = lsz; r.uns = uns; r.off = off;
        r.rd = rd; r.alu = alu; r.pc4 = pc4; r.dst = dst;
        return r;
    endfunction

    // Reference: arithmetic view of the write-back value.
    function automatic logic [31:0] model_data(input instr_t h);
        int unsigned w;
        int unsigned sh;
        if (h.sel == 2'd2) return h.pc4 + 32'd4;
        if (h.sel != 2'd1) return h.alu;
        if (h.lsz == 2'd0) begin
            sh = 8 * (3 - int'(h.off));
            w = (h.rd >> sh) % 256;
            if (!h.uns && w >= 128) w = w + 32'hFFFF_FF00;
            return w;
        end
        if (h.lsz == 2'd1) begin
            w = h.off[1] ? h.rd % 65536 : h.rd / 65536;
            if (!h.uns && w >= 32768) w = w + 32'hFFFF_0000;
            return w;
        end
        return h.rd;
    endfunction

    function automatic logic model_we(input instr_t h);
        return h.v && h.we && (h.dst != 5'd0);
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input instr_t i);
        cur             = i;
        Valid_In        = i.v;
        RegWrite_In     = i.we;
        WbSel_In        = i.sel;
        LoadSize_In     = i.lsz;
        LoadUnsigned_In = i.uns;
        ByteOff_In      = i.off;
        R_Data_In       = i.rd;
        ALUResult_In    = i.alu;
        PCPlus4_In      = i.pc4;
        rDest_In        = i.dst;
    endtask

    task automatic compare_all();
        logic [31:0] ed;
        logic        ew;
        ed = model_data(held);
        ew = model_we(held);
        check("wdata", wd_o, ed);
        check("we", {31'd0, we_o}, {31'd0, ew});
        check("dst", {27'd0, dst_o}, {27'd0, held.dst});
        check("fwd_valid", {31'd0, fv_o}, {31'd0, ew});
        check("fwd_addr", {27'd0, fa_o}, {27'd0, held.dst});
        check("fwd_data", fd_o, ed);
        check("retire", cnt_o, mcnt);
        check("retire4", {28'd0, cnt4_o}, mcnt % 16);
        check("wdata4", wd4_o, ed);
        check("we4", {31'd0, we4_o & fv4_o}, {31'd0, ew});
        check("dst4", {27'd0, dst4_o | fa4_o}, {27'd0, held.dst});
        check("fwd4", fd4_o, ed);
    endtask

    task automatic tick(input logic stall, input logic flush);
        Stall = stall;
        Flush = flush;
        @(posedge Clk);
        if (held.v && (!stall || flush)) mcnt++;
        if (flush) held = '0;
        else if (!stall) held = cur;
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        Rst_n = 1'b0;
        held  = '0;
        mcnt  = 0;
        @(posedge Clk);
        @(posedge Clk);
        #1;
        compare_all();
        #2 Rst_n = 1'b1;
    endtask

    function automatic instr_t rnd_instr();
        return mk($urandom_range(0, 1), $urandom_range(0, 1), 2'($urandom_range(0, 3)),
                  2'($urandom_range(0, 3)), $urandom_range(0, 1), 2'($urandom_range(0, 3)),
                  $urandom, $urandom, $urandom, 5'($urandom_range(0, 31)));
    endfunction

    initial begin
        int unsigned c0;
        Rst_n = 1'b0;
        Stall = 1'b0;
        Flush = 1'b0;
        held  = '0;
        mcnt  = 0;
        drive(mk(1, 1, 2'd0, 2'd0, 0, 2'd0, 32'h1, 32'h5, 32'h9, 5'd7));
        do_reset();

        // Directed vectors.
        tbl.push_back('{"alu", mk(1, 1, 2'd0, 2'd2, 0, 2'd0, 32'h0, 32'h0000_1234, 32'h0, 5'd8),
                        32'h0000_1234, 1'b1});
        tbl.push_back('{"lb0", mk(1, 1, 2'd1, 2'd0, 0, 2'd0, 32'h80FF_7F01, 0, 0, 5'd9),
                        32'hFFFF_FF80, 1'b1});
        tbl.push_back('{"lbu0", mk(1, 1, 2'd1, 2'd0, 1, 2'd0, 32'h80FF_7F01, 0, 0, 5'd9),
                        32'h0000_0080, 1'b1});
        tbl.push_back('{"lb2", mk(1, 1, 2'd1, 2'd0, 0, 2'd2, 32'h80FF_7F01, 0, 0, 5'd9),
                        32'h0000_007F, 1'b1});
        tbl.push_back('{"lb1", mk(1, 1, 2'd1, 2'd0, 0, 2'd1, 32'h80FF_7F01, 0, 0, 5'd9),
                        32'hFFFF_FFFF, 1'b1});
        tbl.push_back('{"lbu3", mk(1, 1, 2'd1, 2'd0, 1, 2'd3, 32'h80FF_7F01, 0, 0, 5'd9),
                        32'h0000_0001, 1'b1});
        tbl.push_back('{"lh0", mk(1, 1, 2'd1, 2'd1, 0, 2'd0, 32'h80FF_7F01, 0, 0, 5'd10),
                        32'hFFFF_80FF, 1'b1});
        tbl.push_back('{"lhu2", mk(1, 1, 2'd1, 2'd1, 1, 2'd2, 32'h80FF_7F01, 0, 0, 5'd10),
                        32'h0000_7F01, 1'b1});
        tbl.push_back('{"lh1", mk(1, 1, 2'd1, 2'd1, 0, 2'd1, 32'h80FF_7F01, 0, 0, 5'd10),
                        32'hFFFF_80FF, 1'b1});
        tbl.push_back('{"lw", mk(1, 1, 2'd1, 2'd2, 0, 2'd1, 32'h80FF_7F01, 0, 0, 5'd11),
                        32'h80FF_7F01, 1'b1});
        tbl.push_back('{"link", mk(1, 1, 2'd2, 2'd0, 0, 2'd0, 0, 0, 32'h0040_0010, 5'd31),
                        32'h0040_0014, 1'b1});
        tbl.push_back('{"link_r0", mk(1, 1, 2'd2, 2'd0, 0, 2'd0, 0, 0, 32'h0040_0010, 5'd0),
                        32'h0040_0014, 1'b0});
        tbl.push_back('{"link_wrap", mk(1, 1, 2'd2, 2'd0, 0, 2'd0, 0, 0, 32'hFFFF_FFFE, 5'd2),
                        32'h0000_0002, 1'b1});
        tbl.push_back('{"rsvd_sel", mk(1, 1, 2'd3, 2'd0, 0, 2'd0, 32'h1, 32'hDEAD, 32'h0, 5'd4),
                        32'h0000_DEAD, 1'b1});
        tbl.push_back('{"invalid", mk(0, 1, 2'd0, 2'd0, 0, 2'd0, 0, 32'h77, 0, 5'd4),
                        32'h0000_0077, 1'b0});
        tbl.push_back('{"no_write", mk(1, 0, 2'd0, 2'd0, 0, 2'd0, 0, 32'h66, 0, 5'd4),
                        32'h0000_0066, 1'b0});

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].in);
            tick(1'b0, 1'b0);
            check({tbl[i].name, "_data"}, wd_o, tbl[i].exp_d);
            check({tbl[i].name, "_we"}, {31'd0, we_o}, {31'd0, tbl[i].exp_we});
            check({tbl[i].name, "_fwd"}, {31'd0, fv_o}, {31'd0, tbl[i].exp_we});
            if (i == 1) check("alu_retired", cnt_o, 32'd1);
        end

        // Stall holds contents; the instruction is counted once when released.
        drive(mk(1, 1, 2'd0, 2'd0, 0, 2'd0, 0, 32'hAA, 0, 5'd5));
        tick(1'b0, 1'b0);
        c0 = mcnt;
        for (int i = 0; i < 3; i++) begin
            drive(rnd_instr());
            tick(1'b1, 1'b0);
            check("stall_hold", wd_o, 32'hAA);
            check("stall_cnt", cnt_o, c0);
        end
        drive(mk(1, 1, 2'd0, 2'd0, 0, 2'd0, 0, 32'hBB, 0, 5'd6));
        tick(1'b0, 1'b0);
        check("release_cnt", cnt_o, c0 + 1);
        check("release_data", wd_o, 32'hBB);
        drive(mk(1, 1, 2'd0, 2'd0, 0, 2'd0, 0, 32'hCC, 0, 5'd6));
        tick(1'b1, 1'b1);
        check("flush_wins", {31'd0, we_o}, 32'd0);

        // Asynchronous reset between edges clears outputs without a clock edge.
        drive(mk(1, 1, 2'd0, 2'd0, 0, 2'd0, 0, 32'h55, 0, 5'd3));
        tick(1'b0, 1'b0);
        check("pre_reset_we", {31'd0, we_o}, 32'd1);
        #2 Rst_n = 1'b0;
        held = '0;
        mcnt = 0;
        #1;
        check("async_we", {31'd0, we_o}, 32'd0);
        check("async_data", wd_o, 32'd0);
        compare_all();
        #1 Rst_n = 1'b1;
        drive(mk(1, 1, 2'd0, 2'd0, 0, 2'd0, 0, 32'h99, 0, 5'd12));
        tick(1'b0, 1'b0);
        check("post_reset_cap", wd_o, 32'h99);

        // Counter wrap: 17 retirements on the 4-bit counter.
        do_reset();
        for (int i = 0; i < 17; i++) begin
            drive(mk(1, 0, 2'd0, 2'd0, 0, 2'd0, 0, i, 0, 5'd1));
            tick(1'b0, 1'b0);
        end
        drive(mk(0, 0, 2'd0, 2'd0, 0, 2'd0, 0, 0, 0, 5'd0));
        tick(1'b0, 1'b0);
        check("wrap4", {28'd0, cnt4_o}, 32'd1);
        check("wrap32", cnt_o, 32'd17);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            drive(rnd_instr());
            tick($urandom_range(0, 4) == 0, $urandom_range(0, 9) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
